// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the seven-segment scan driver.
// lz_keep_mask is only referenced when SEG7_LZ_BLANK_EN is defined.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef logic [2:0] digit_idx_t;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Keeps every digit at or below the most significant nonzero nibble.
  // Digit 0 always survives so an all-zero word still shows one "0".
  function automatic logic [7:0] lz_keep_mask(input logic [31:0] word);
    logic [7:0] keep;
    logic       seen;
    keep = 8'h01;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (word[4*i +: 4] != 4'h0) begin
        seen = 1'b1;
      end
      keep[i] = seen;
    end
    return keep;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode display driver with per-frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              A2G,
  output logic                    DP,
  output logic                    frame_tick
);

  localparam int                 CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam digit_idx_t         IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          cnt_reg;
  logic [CNT_W-1:0]          cnt_next;
  digit_idx_t                idx_reg;
  digit_idx_t                idx_next;
  logic                      digit_wrap;
  logic                      frame_wrap;

  logic [4*NUM_DIGITS-1:0]   snap_data_reg;
  logic [NUM_DIGITS-1:0]     snap_en_reg;
  logic [NUM_DIGITS-1:0]     snap_dp_reg;
  logic [NUM_DIGITS-1:0]     snap_en_next;
  logic [NUM_DIGITS-1:0]     snap_dp_next;

  logic [3:0]                nibble;
  logic [6:0]                seg_dec;
  logic                      digit_lit;
  logic [NUM_DIGITS-1:0]     an_next;
  logic [6:0]                a2g_next;
  logic                      dp_next;

  // Prescaler and digit index.
  always_comb begin
    digit_wrap = (cnt_reg == CNT_LAST);
    frame_wrap = digit_wrap && (idx_reg == IDX_LAST);
    cnt_next   = digit_wrap ? '0 : cnt_reg + CNT_W'(1);
    idx_next   = digit_wrap ? idx_reg + digit_idx_t'(1) : idx_reg;
  end

  // Snapshot values captured at the 7 -> 0 wrap.
`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_keep;

  always_comb begin
    lz_keep      = lz_keep_mask(data);
    snap_en_next = digit_en & lz_keep;
    snap_dp_next = dp_in & lz_keep;
  end
`else
  always_comb begin
    snap_en_next = digit_en;
    snap_dp_next = dp_in;
  end
`endif

  // Output stage: decode only the digit currently selected by idx_reg.
  always_comb begin
    nibble    = snap_data_reg[{idx_reg, 2'b00} +: 4];
    digit_lit = snap_en_reg[idx_reg];
    a2g_next  = digit_lit ? seg_dec : SEG_BLANK;
    dp_next   = digit_lit ? ~snap_dp_reg[idx_reg] : 1'b1;
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // At most one anode can be driven low because idx_reg matches a single digit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign an_next[gi] = !(snap_en_reg[gi] && (idx_reg == digit_idx_t'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      snap_data_reg <= '0;
      snap_en_reg   <= '0;
      snap_dp_reg   <= '0;
      AN            <= AN_OFF[NUM_DIGITS-1:0];
      A2G           <= SEG_BLANK;
      DP            <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        snap_data_reg <= data;
        snap_en_reg   <= snap_en_next;
        snap_dp_reg   <= snap_dp_next;
      end
      AN  <= an_next;
      A2G <= a2g_next;
      DP  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with SCAN_DIV=4.
// Expectations for leading-zero blanking apply when SEG7_LZ_BLANK_EN is defined.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic [7:0]  AN;
  logic [6:0]  A2G;
  logic        DP;
  logic        frame_tick;

  int total;
  int bad;

  // Hand-decoded segments for 89ABCDEF, digit 0 first.
  logic [6:0] scan_seg [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

  seg7_scan_driver #(
    .SCAN_DIV   (4),
    .NUM_DIGITS (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .AN         (AN),
    .A2G        (A2G),
    .DP         (DP),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      if (frame_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    data     = 32'h89ABCDEF;
    digit_en = 8'hFF;
    dp_in    = 8'h00;
    #1 reset = 1'b1;
    #1;
    total++; if (AN !== 8'hFF) begin bad++; $display("FAIL reset_an: got %h want ff", AN); end
    total++; if (A2G !== 7'h7F) begin bad++; $display("FAIL reset_a2g: got %h want 7f", A2G); end
    total++; if (DP !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", DP); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    repeat (3) @(negedge clk);
    total++; if (AN !== 8'hFF || A2G !== 7'h7F) begin bad++; $display("FAIL reset_held: AN=%h A2G=%h want ff/7f", AN, A2G); end
    $display("test_reset: done");
  endtask

  task automatic test_full_scan;
    int n;
    bit ok;
    int d;
    logic [7:0] exp_an;
    reset = 1'b0;
    n = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      if (frame_tick === 1'b1) ok = 1'b1;
      else if (AN !== 8'hFF) begin
        total++; bad++; $display("FAIL prescan_blank: cycle %0d AN=%h want ff", n, AN);
      end
    end
    total++; if (!ok || n != 32) begin bad++; $display("FAIL first_tick: seen=%0b after %0d cycles want 32", ok, n); end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d = k / 4;
      exp_an = ~(8'h01 << d);
      total++; if (AN !== exp_an || A2G !== scan_seg[d] || DP !== 1'b1) begin
        bad++; $display("FAIL scan_k%0d: AN=%h A2G=%h DP=%b want %h/%h/1", k, AN, A2G, DP, exp_an, scan_seg[d]);
      end
      total++; if (frame_tick !== (k == 31)) begin
        bad++; $display("FAIL tick_period_k%0d: got %b want %b", k, frame_tick, (k == 31));
      end
    end
    $display("test_full_scan: done");
  endtask

  task automatic test_tear_free;
    int d;
    logic [7:0] exp_an;
    logic [7:0] exp_an1;
    logic [6:0] exp_seg1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d = k / 4;
      exp_an = ~(8'h01 << d);
      total++; if (AN !== exp_an || A2G !== scan_seg[d]) begin
        bad++; $display("FAIL tear_old_k%0d: AN=%h A2G=%h want %h/%h", k, AN, A2G, exp_an, scan_seg[d]);
      end
      if (k == 12) data = 32'h00000000;
    end
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL tear_tick: got %b want 1", frame_tick); end
`ifdef SEG7_LZ_BLANK_EN
    exp_an1 = 8'hFF; exp_seg1 = 7'h7F;
`else
    exp_an1 = 8'hFD; exp_seg1 = 7'h40;
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 4) begin
        total++; if (AN !== 8'hFE || A2G !== 7'h40) begin
          bad++; $display("FAIL tear_new_d0_k%0d: AN=%h A2G=%h want fe/40", k, AN, A2G);
        end
      end else begin
        total++; if (AN !== exp_an1 || A2G !== exp_seg1) begin
          bad++; $display("FAIL tear_new_d1_k%0d: AN=%h A2G=%h want %h/%h", k, AN, A2G, exp_an1, exp_seg1);
        end
      end
    end
    $display("test_tear_free: done");
  endtask

  task automatic test_masks;
    int n;
    bit ok;
    int d;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    digit_en = 8'h05;
    dp_in    = 8'h04;
    data     = 32'h00000321;
    wait_tick(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL mask_tick: no frame_tick within %0d cycles", n); end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d = k / 4;
      if (d == 0) begin
        exp_an = 8'hFE; exp_seg = 7'h79; exp_dp = 1'b1;
      end else if (d == 2) begin
        exp_an = 8'hFB; exp_seg = 7'h30; exp_dp = 1'b0;
      end else begin
        exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      total++; if (AN !== exp_an || A2G !== exp_seg || DP !== exp_dp) begin
        bad++; $display("FAIL mask_k%0d: AN=%h A2G=%h DP=%b want %h/%h/%b", k, AN, A2G, DP, exp_an, exp_seg, exp_dp);
      end
    end
    $display("test_masks: done");
  endtask

  task automatic test_reset_mid;
    int n;
    bit ok;
    data     = 32'h89ABCDEF;
    digit_en = 8'hFF;
    dp_in    = 8'h00;
    wait_tick(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_tick: no frame_tick within %0d cycles", n); end
    repeat (21) @(negedge clk);
    total++; if (AN !== 8'hDF || A2G !== 7'h08) begin
      bad++; $display("FAIL rmid_digit5: AN=%h A2G=%h want df/08", AN, A2G);
    end
    reset = 1'b1;
    #1;
    total++; if (AN !== 8'hFF || A2G !== 7'h7F || DP !== 1'b1 || frame_tick !== 1'b0) begin
      bad++; $display("FAIL rmid_async: AN=%h A2G=%h DP=%b tick=%b want ff/7f/1/0", AN, A2G, DP, frame_tick);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (AN !== 8'hFF || A2G !== 7'h7F) begin
        bad++; $display("FAIL rmid_hold_k%0d: AN=%h A2G=%h want ff/7f", k, AN, A2G);
      end
    end
    reset = 1'b0;
    n = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      if (frame_tick === 1'b1) ok = 1'b1;
      else if (AN !== 8'hFF) begin
        total++; bad++; $display("FAIL rmid_blank: cycle %0d AN=%h want ff", n, AN);
      end
    end
    total++; if (!ok || n != 32) begin bad++; $display("FAIL rmid_restart: seen=%0b after %0d cycles want 32", ok, n); end
    @(negedge clk);
    total++; if (AN !== 8'hFE || A2G !== 7'h0E) begin
      bad++; $display("FAIL rmid_resume: AN=%h A2G=%h want fe/0e", AN, A2G);
    end
    $display("test_reset_mid: done");
  endtask

`ifdef SEG7_LZ_BLANK_EN
  task automatic test_lz_blank;
    int n;
    bit ok;
    int d;
    logic [6:0] lz_seg [3] = '{7'h12, 7'h40, 7'h08};
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    data     = 32'h00000A05;
    digit_en = 8'hFF;
    dp_in    = 8'h00;
    wait_tick(n, ok);
    total++; if (!ok) begin bad++; $display("FAIL lz_tick: no frame_tick within %0d cycles", n); end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d = k / 4;
      if (d < 3) begin exp_an = ~(8'h01 << d); exp_seg = lz_seg[d]; end
      else begin exp_an = 8'hFF; exp_seg = 7'h7F; end
      total++; if (AN !== exp_an || A2G !== exp_seg) begin
        bad++; $display("FAIL lz_a05_k%0d: AN=%h A2G=%h want %h/%h", k, AN, A2G, exp_an, exp_seg);
      end
      if (k == 16) data = 32'h00000000;
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d = k / 4;
      if (d == 0) begin exp_an = 8'hFE; exp_seg = 7'h40; end
      else begin exp_an = 8'hFF; exp_seg = 7'h7F; end
      total++; if (AN !== exp_an || A2G !== exp_seg) begin
        bad++; $display("FAIL lz_zero_k%0d: AN=%h A2G=%h want %h/%h", k, AN, A2G, exp_an, exp_seg);
      end
    end
    $display("test_lz_blank: done");
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full_scan();
    test_tear_free();
    test_masks();
    test_reset_mid();
`ifdef SEG7_LZ_BLANK_EN
    test_lz_blank();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
- Sits directly downstream of the memory-mapped I/O decoder. The decoder supplies a 32-bit display word plus digit-enable and decimal-point masks; this block produces the AN/A2G/DP pin levels.
- Snapshots the display word once per frame so a CPU store never tears a frame.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit is lit (1 kHz digit rate at 100 MHz); legal range >= 2.
- NUM_DIGITS, 8, number of digits scanned; fixed at 8 for this board; the index is 3 bits.

Ports:
- clk  input  1  system clock (100 MHz on board).
- reset  input  1  asynchronous, active-high reset.
- data  input  32  display word; nibble i (data[4i+3:4i]) drives digit i; digit 0 is rightmost.
- digit_en  input  8  per-digit enable; 0 blanks that digit.
- dp_in  input  8  per-digit decimal point, active-high request.
- AN  output  8  digit anodes, active-low.
- A2G  output  7  segments, active-low; A2G[0]=a … A2G[6]=g.
- DP  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse at each frame start (snapshot taken).

Behaviour:
- Registers:
  - prescaler cnt, 0..SCAN_DIV-1.
  - digit index idx, 3 bits.
  - snapshot registers snap_data, snap_en, snap_dp.
  - output registers AN/A2G/DP/frame_tick.
- Reset (async, immediate):
  - cnt=0, idx=0, snapshots=0.
  - AN=8'hFF, A2G=7'h7F, DP=1, frame_tick=0.
- Prescaler:
  - cnt increments every cycle.
  - At cnt==SCAN_DIV-1, cnt wraps to 0 and idx advances. idx wraps 7→0, no skipping.
- Frame snapshot:
  - On the same edge where idx wraps 7→0, capture snap_data<=data, snap_en<=digit_en, snap_dp<=dp_in.
  - frame_tick is 1 for exactly the following cycle.
  - The first snapshot after reset occurs at the first 7→0 wrap. Until then all outputs stay blank (snap_en=0).
- Output stage (registered, 1-cycle latency from idx/snapshot):
  - AN = ~(8'b1<<idx) when snap_en[idx], else 8'hFF.
  - A2G = hex decode of snap_data nibble idx when snap_en[idx], else 7'h7F.
  - DP = ~snap_dp[idx] when snap_en[idx], else 1.
- Hex decode (active-low):
  - 0 → 40, 1 → 79, 2 → 24, 3 → 30, 4 → 19, 5 → 12, 6 → 02, 7 → 78.
  - 8 → 00, 9 → 10, A → 08, b → 03, C → 46, d → 21, E → 06, F → 0E.
- Input changes mid-frame have no effect until the next 7→0 wrap.
- Reset asserted mid-scan blanks outputs immediately. Scanning restarts from digit 0 with cnt=0 after deassertion.
- Exactly one AN bit is low at any time, or none.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN
- Defined:
  - At snapshot, compute a leading-zero mask: digits above the most significant nonzero nibble are removed from snap_en.
  - Digit 0 is never suppressed, so data=0 shows a single "0".
  - Suppression is ANDed with digit_en; dp_in on a suppressed digit is also blanked.
- Undefined: no suppression; all enabled digits show their nibble, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'h7F.
  - AN_OFF = 8'hFF.
  - the 16-entry hex-to-segment constant table.
  - typedef digit_idx_t (logic [2:0]).
- Sub-module hex_to_seg7: combinational, 4-bit nibble in, 7-bit active-low segments out, implemented from the package table.
- The scan driver instantiates one hex_to_seg7 after the nibble mux.

Test Plan (SCAN_DIV=4 unless noted):
- Reset: hold reset, toggle clk → AN=FF, A2G=7F, DP=1, frame_tick=0. Assert reset asynchronously between edges → outputs blank before the next edge.
- Full scan: data=32'h89ABCDEF, digit_en=FF, dp_in=00.
  - After the first frame_tick, AN cycles FE,FD,FB,…,7F, each held 4 cycles.
  - A2G sequence is 0E,06,21,46,03,08,10,00.
  - frame_tick has period 32 cycles.
- Tear-free: change data to 32'h00000000 while idx=3 → remaining digits of that frame still show the old value; new value appears from digit 0 of the next frame, one cycle after frame_tick.
- Masks: digit_en=8'h05, dp_in=8'h04, data=32'h00000321.
  - Digit 0: AN=FE, A2G=79.
  - Digit 2: AN=FB, A2G=30, DP=0.
  - Digits 1 and 3–7: AN=FF, A2G=7F, DP=1.
- Reset mid-operation: assert reset at idx=5 for 3 cycles → blank immediately; after release, blank until the first frame_tick (32 cycles), then scanning resumes from digit 0.
- With SEG7_LZ_BLANK_EN:
  - data=32'h00000A05, digit_en=FF → only digits 0–2 light (05→12, 0→40, A→08).
  - data=0 → only digit 0 lights, showing 40.
